// File: rtl/serdes_pkg.sv
// Shared symbol constants and scheduler state encoding for the serial TX path.
package serdes_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K28_0 = 8'h1C;  // in-frame fill on underrun

  typedef enum logic [2:0] {
    ALIGN = 3'd0,
    IDLE  = 3'd1,
    SOF   = 3'd2,
    DATA  = 3'd3,
    EOF   = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_Ptr wins.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_Req,
  input  logic [IW-1:0]    i_Ptr,
  output logic [N_REQ-1:0] o_Grant,
  output logic [IW-1:0]    o_Idx
);

  int w_idx;

  // Walk from farthest to nearest so the nearest request overwrites.
  always_comb begin
    o_Grant = '0;
    o_Idx   = '0;
    w_idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = (int'(i_Ptr) + i) % N_REQ;
      if (i_Req[w_idx]) begin
        o_Grant        = '0;
        o_Grant[w_idx] = 1'b1;
        o_Idx          = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Symbol scheduler ahead of the 8b/10b encoder: comma alignment, RR framing,
// underrun fill and MAX_LEN truncation. State reflects the symbol on o_Sym.
//   state | meaning
//   ALIGN | post-reset commas until ALIGN_COUNT taken
//   IDLE  | inter-frame commas, arbitrate once gap is met
//   SOF   | o_Sym holds SOF for the latched owner
//   DATA  | o_Sym holds a data byte or FILL
//   EOF   | o_Sym holds EOF, pointer advances on take
module serdes_tx_scheduler
  import serdes_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int ALIGN_COUNT = 16,
  parameter  int MIN_IFG     = 2,
  parameter  int MAX_LEN     = 256,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic               i_Clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_Data,
  input  logic [N_REQ-1:0]   i_Last,
  output logic [N_REQ-1:0]   o_Ack,
  input  logic               i_Enc_Ready,
  output logic [7:0]         o_Sym,
  output logic               o_K,
  output logic [IW-1:0]      o_Owner,
  output logic               o_Busy,
  output logic               o_Err
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(ALIGN_COUNT + 1);
  localparam int GW = $clog2(MIN_IFG + 1);

  state_t           r_state, w_state_next;
  logic [7:0]       r_sym, w_sym_next;
  logic             r_k, w_k_next;
  logic [IW-1:0]    r_owner, r_ptr, w_ptr_next;
  logic [BW-1:0]    r_byte_cnt, w_cnt_inc;
  logic [AW-1:0]    r_align_cnt;
  logic [GW-1:0]    r_gap;
  logic             r_end, r_trunc, r_err;
  logic             w_load_data, w_load_eof, w_own_req, w_own_last;
  logic             w_gap_met, w_align_done;
  logic [7:0]       w_own_data;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_grant_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_Req   (i_Req),
    .i_Ptr   (r_ptr),
    .o_Grant (w_grant),
    .o_Idx   (w_grant_idx)
  );

  assign w_own_req    = i_Req[r_owner];
  assign w_own_last   = i_Last[r_owner];
  assign w_own_data   = i_Data[{r_owner, 3'b000} +: 8];
  assign w_cnt_inc    = r_byte_cnt + BW'(1);
  // Gap includes the comma being taken now, so back-to-back frames see exactly MIN_IFG.
  assign w_gap_met    = (int'(r_gap) + 1) >= MIN_IFG;
  assign w_align_done = r_align_cnt >= AW'(ALIGN_COUNT - 1);
  assign w_ptr_next   = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) r_state <= ALIGN;
    else if (i_Enc_Ready) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ALIGN:   if (w_align_done) w_state_next = IDLE;
      IDLE:    if (w_gap_met && |w_grant) w_state_next = SOF;
      SOF:     w_state_next = DATA;
      DATA:    if (r_end) w_state_next = EOF;
      EOF:     w_state_next = IDLE;
      default: w_state_next = ALIGN;
    endcase
  end

  always_comb begin
    w_load_data = (r_state == SOF) || (r_state == DATA && !r_end);
    w_load_eof  = (r_state == DATA) && r_end;
    w_sym_next  = K28_5;
    w_k_next    = 1'b1;
    if (r_state == IDLE && w_state_next == SOF) begin
      w_sym_next = K27_7;
    end else if (w_load_data) begin
      w_sym_next = w_own_req ? w_own_data : K28_0;
      w_k_next   = !w_own_req;
    end else if (w_load_eof) begin
      w_sym_next = K29_7;
    end
    o_Ack  = (w_load_data && i_Enc_Ready && w_own_req) ? (N_REQ'(1) << r_owner) : '0;
    o_Busy = (r_state == SOF) || (r_state == DATA) || (r_state == EOF);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      r_sym       <= K28_5;
      r_k         <= 1'b1;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_byte_cnt  <= '0;
      r_align_cnt <= '0;
      r_gap       <= '0;
      r_end       <= 1'b0;
      r_trunc     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_Enc_Ready) begin
        r_sym <= w_sym_next;
        r_k   <= w_k_next;
        r_err <= w_load_eof && r_trunc;
        if (r_state == ALIGN && r_align_cnt != AW'(ALIGN_COUNT))
          r_align_cnt <= r_align_cnt + AW'(1);
        if (r_state == EOF) begin
          r_gap <= '0;
          r_ptr <= w_ptr_next;
        end else if (r_state == IDLE && r_gap != GW'(MIN_IFG)) begin
          r_gap <= r_gap + GW'(1);
        end
        if (r_state == IDLE && w_state_next == SOF) begin
          r_owner    <= w_grant_idx;
          r_byte_cnt <= '0;
          r_end      <= 1'b0;
          r_trunc    <= 1'b0;
        end else if (w_load_data && w_own_req) begin
          r_byte_cnt <= w_cnt_inc;
          if (w_own_last || w_cnt_inc == BW'(MAX_LEN)) r_end <= 1'b1;
          r_trunc <= !w_own_last && (w_cnt_inc == BW'(MAX_LEN));
        end
      end
    end
  end

  assign o_Sym   = r_sym;
  assign o_K     = r_k;
  assign o_Owner = r_owner;
  assign o_Err   = r_err;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Directed bench for serdes_tx_scheduler (N_REQ=4, ALIGN_COUNT=16, MIN_IFG=2, MAX_LEN=4).
module tb_serdes_tx_scheduler;

  logic        i_Clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_Req;
  logic [31:0] i_Data;
  logic [3:0]  i_Last;
  logic [3:0]  o_Ack;
  logic        i_Enc_Ready;
  logic [7:0]  o_Sym;
  logic        o_K;
  logic [1:0]  o_Owner;
  logic        o_Busy;
  logic        o_Err;

  int checks = 0;
  int errors = 0;
  int acks[4];

  serdes_tx_scheduler #(
    .N_REQ(4), .ALIGN_COUNT(16), .MIN_IFG(2), .MAX_LEN(4)
  ) dut (
    .i_Clk       (i_Clk),
    .i_rst_n     (i_rst_n),
    .i_Req       (i_Req),
    .i_Data      (i_Data),
    .i_Last      (i_Last),
    .o_Ack       (o_Ack),
    .i_Enc_Ready (i_Enc_Ready),
    .o_Sym       (o_Sym),
    .o_K         (o_K),
    .o_Owner     (o_Owner),
    .o_Busy      (o_Busy),
    .o_Err       (o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acks are tallied just before each edge, once inputs have settled.
  task automatic tick();
    #1;
    for (int r = 0; r < 4; r++) if (o_Ack[r]) acks[r]++;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic exp_sym(input string tag, input logic [7:0] s, input logic k, input logic busy);
    chk({tag, ".sym"}, 32'(o_Sym), 32'(s));
    chk({tag, ".k"}, 32'(o_K), 32'(k));
    chk({tag, ".busy"}, 32'(o_Busy), 32'(busy));
  endtask

  task automatic chk_ack(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, 32'(o_Ack), 32'(exp));
  endtask

  task automatic put(input int r, input logic [7:0] b, input logic last);
    i_Data[8*r +: 8] = b;
    i_Last[r]        = last;
  endtask

  task automatic clr_acks();
    for (int r = 0; r < 4; r++) acks[r] = 0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_Req = '0; i_Data = '0; i_Last = '0; i_Enc_Ready = 1'b1;
    clr_acks();
    tick(); tick();
    exp_sym("rst", 8'hBC, 1'b1, 1'b0);
    chk("rst.ack", 32'(o_Ack), 32'h0);
    chk("rst.owner", 32'(o_Owner), 32'h0);
    chk("rst.err", 32'(o_Err), 32'h0);
    i_rst_n = 1'b1;

    // No requests: commas forever
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_sym("idle", 8'hBC, 1'b1, 1'b0);
      chk("idle.ack", 32'(o_Ack), 32'h0);
    end

    // Requester 1, three bytes
    i_Req = 4'b0010; put(1, 8'h11, 1'b0);
    chk_ack("t2.ack.idle", 4'b0000);
    tick(); exp_sym("t2.sof", 8'hFB, 1'b1, 1'b1);
    chk("t2.owner", 32'(o_Owner), 32'd1);
    chk_ack("t2.ack11", 4'b0010);
    tick(); exp_sym("t2.d11", 8'h11, 1'b0, 1'b1);
    put(1, 8'h22, 1'b0); chk_ack("t2.ack22", 4'b0010);
    tick(); exp_sym("t2.d22", 8'h22, 1'b0, 1'b1);
    put(1, 8'h33, 1'b1); chk_ack("t2.ack33", 4'b0010);
    tick(); exp_sym("t2.d33", 8'h33, 1'b0, 1'b1);
    i_Req = '0; i_Last = '0; chk_ack("t2.ack.end", 4'b0000);
    tick(); exp_sym("t2.eof", 8'hFD, 1'b1, 1'b1);
    tick(); exp_sym("t2.ifg0", 8'hBC, 1'b1, 1'b0);
    tick(); exp_sym("t2.ifg1", 8'hBC, 1'b1, 1'b0);
    chk("t2.ackcnt", 32'(acks[1]), 32'd3);

    // All four requesting 1-byte packets from reset
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    i_Req = 4'b1111; i_Last = 4'b1111; i_Data = 32'hA3A2A1A0;
    for (int i = 1; i <= 17; i++) begin
      tick(); exp_sym("t3.align", 8'hBC, 1'b1, 1'b0);
      chk("t3.align.ack", 32'(o_Ack), 32'h0);
    end
    for (int f = 0; f < 5; f++) begin
      tick(); exp_sym("t3.sof", 8'hFB, 1'b1, 1'b1);
      chk("t3.owner", 32'(o_Owner), 32'(f % 4));
      tick(); exp_sym("t3.data", 8'(8'hA0 + f % 4), 1'b0, 1'b1);
      tick(); exp_sym("t3.eof", 8'hFD, 1'b1, 1'b1);
      if (f < 4) begin
        tick(); exp_sym("t3.ifg0", 8'hBC, 1'b1, 1'b0);
        tick(); exp_sym("t3.ifg1", 8'hBC, 1'b1, 1'b0);
      end
    end
    i_Req = '0; i_Last = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_sym("t3.tail", 8'hBC, 1'b1, 1'b0);
    end

    // Requester 0 underruns for two slots
    clr_acks();
    i_Req = 4'b0001; put(0, 8'h50, 1'b0);
    tick(); exp_sym("t4.sof", 8'hFB, 1'b1, 1'b1);
    chk("t4.owner", 32'(o_Owner), 32'd0);
    chk_ack("t4.ack50", 4'b0001);
    tick(); exp_sym("t4.d50", 8'h50, 1'b0, 1'b1);
    put(0, 8'h51, 1'b0);
    tick(); exp_sym("t4.d51", 8'h51, 1'b0, 1'b1);
    i_Req = '0; chk_ack("t4.ack.gap0", 4'b0000);
    tick(); exp_sym("t4.fill0", 8'h1C, 1'b1, 1'b1);
    chk_ack("t4.ack.gap1", 4'b0000);
    tick(); exp_sym("t4.fill1", 8'h1C, 1'b1, 1'b1);
    i_Req = 4'b0001; put(0, 8'h52, 1'b1); chk_ack("t4.ack52", 4'b0001);
    tick(); exp_sym("t4.d52", 8'h52, 1'b0, 1'b1);
    i_Req = '0; i_Last = '0;
    tick(); exp_sym("t4.eof", 8'hFD, 1'b1, 1'b1);
    tick(); exp_sym("t4.ifg0", 8'hBC, 1'b1, 1'b0);
    tick(); exp_sym("t4.ifg1", 8'hBC, 1'b1, 1'b0);
    chk("t4.ackcnt", 32'(acks[0]), 32'd3);

    // Requester 2 with encoder stalls mid-frame
    clr_acks();
    i_Req = 4'b0100; put(2, 8'h61, 1'b0);
    tick(); exp_sym("t5.sof", 8'hFB, 1'b1, 1'b1);
    chk("t5.owner", 32'(o_Owner), 32'd2);
    i_Enc_Ready = 1'b0; chk_ack("t5.ack.stall0", 4'b0000);
    tick(); exp_sym("t5.hold.sof", 8'hFB, 1'b1, 1'b1);
    i_Enc_Ready = 1'b1; chk_ack("t5.ack61", 4'b0100);
    tick(); exp_sym("t5.d61", 8'h61, 1'b0, 1'b1);
    put(2, 8'h62, 1'b0); i_Enc_Ready = 1'b0; chk_ack("t5.ack.stall1", 4'b0000);
    tick(); exp_sym("t5.hold61", 8'h61, 1'b0, 1'b1);
    i_Enc_Ready = 1'b1; chk_ack("t5.ack62", 4'b0100);
    tick(); exp_sym("t5.d62", 8'h62, 1'b0, 1'b1);
    put(2, 8'h63, 1'b1);
    tick(); exp_sym("t5.d63", 8'h63, 1'b0, 1'b1);
    i_Req = '0; i_Last = '0; i_Enc_Ready = 1'b0;
    tick(); exp_sym("t5.hold63", 8'h63, 1'b0, 1'b1);
    i_Enc_Ready = 1'b1;
    tick(); exp_sym("t5.eof", 8'hFD, 1'b1, 1'b1);
    tick(); exp_sym("t5.ifg0", 8'hBC, 1'b1, 1'b0);
    tick(); exp_sym("t5.ifg1", 8'hBC, 1'b1, 1'b0);
    chk("t5.ackcnt", 32'(acks[2]), 32'd3);

    // Requester 3, 6-byte packet truncated at MAX_LEN=4
    clr_acks();
    i_Req = 4'b1000; put(3, 8'h71, 1'b0);
    tick(); exp_sym("t6.sof", 8'hFB, 1'b1, 1'b1);
    chk("t6.owner", 32'(o_Owner), 32'd3);
    chk_ack("t6.ack71", 4'b1000);
    tick(); exp_sym("t6.d71", 8'h71, 1'b0, 1'b1);
    put(3, 8'h72, 1'b0);
    tick(); exp_sym("t6.d72", 8'h72, 1'b0, 1'b1);
    put(3, 8'h73, 1'b0);
    tick(); exp_sym("t6.d73", 8'h73, 1'b0, 1'b1);
    put(3, 8'h74, 1'b0);
    tick(); exp_sym("t6.d74", 8'h74, 1'b0, 1'b1);
    put(3, 8'h75, 1'b0); chk_ack("t6.ack.max", 4'b0000);
    chk("t6.err.pre", 32'(o_Err), 32'h0);
    tick(); exp_sym("t6.eof", 8'hFD, 1'b1, 1'b1);
    chk("t6.err.pulse", 32'(o_Err), 32'h1);
    tick(); exp_sym("t6.ifg0", 8'hBC, 1'b1, 1'b0);
    chk("t6.err.clr", 32'(o_Err), 32'h0);
    tick(); exp_sym("t6.ifg1", 8'hBC, 1'b1, 1'b0);
    tick(); exp_sym("t6.sof2", 8'hFB, 1'b1, 1'b1);
    chk("t6.owner2", 32'(o_Owner), 32'd3);
    chk_ack("t6.ack75", 4'b1000);
    tick(); exp_sym("t6.d75", 8'h75, 1'b0, 1'b1);
    put(3, 8'h76, 1'b1);
    tick(); exp_sym("t6.d76", 8'h76, 1'b0, 1'b1);
    i_Req = '0; i_Last = '0;
    tick(); exp_sym("t6.eof2", 8'hFD, 1'b1, 1'b1);
    chk("t6.err.none", 32'(o_Err), 32'h0);
    tick(); exp_sym("t6.ifg2", 8'hBC, 1'b1, 1'b0);
    tick(); exp_sym("t6.ifg3", 8'hBC, 1'b1, 1'b0);
    chk("t6.ackcnt", 32'(acks[3]), 32'd6);

    // Reset in the middle of a frame
    i_Req = 4'b0001; put(0, 8'h81, 1'b0);
    tick(); exp_sym("t7.sof", 8'hFB, 1'b1, 1'b1);
    chk("t7.owner", 32'(o_Owner), 32'd0);
    tick(); exp_sym("t7.d81", 8'h81, 1'b0, 1'b1);
    put(0, 8'h82, 1'b0); i_rst_n = 1'b0;
    tick(); exp_sym("t7.rst", 8'hBC, 1'b1, 1'b0);
    chk("t7.ack", 32'(o_Ack), 32'h0);
    chk("t7.err", 32'(o_Err), 32'h0);
    i_rst_n = 1'b1; i_Req = '0;
    tick(); exp_sym("t7.align", 8'hBC, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
